fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 25 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 30 +++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 tb/tb_fifo_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit path.
// Build option: FIFO_UART_TX_PARITY_EN adds an even-parity bit to every frame.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Symbol timer: emits a one-cycle tick every SYMBOL_EDGE_TIME clocks,
// restarting from zero whenever clear is held.
module baud_tick_gen #(
    parameter int SYMBOL_EDGE_TIME = 1085
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running symbol counter that wraps on the last cycle of each symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO and serializes each byte onto a UART line
// (start, 8 data bits LSB first, stop). With FIFO_UART_TX_PARITY_EN defined an
// even-parity bit is sent between the data bits and the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    output logic       serial_out,
    output logic       busy
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

    state_t                 state;
    state_t                 state_nxt;
    logic                   tick;
    logic                   baud_clear;
    logic [DATA_BITS-1:0]   shift_q;
    logic [2:0]             bit_cnt;
    logic                   serial_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    // The symbol timer restarts while idle and right before the start bit
    assign baud_clear = (state == IDLE) || (state == LOAD);

    baud_tick_gen #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a FIFO that empties during FETCH aborts back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = FETCH;
            FETCH:   state_nxt = fifo_empty ? IDLE : LOAD;
            LOAD:    state_nxt = START;
            START:   if (tick) state_nxt = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:    if (tick && (bit_cnt == 3'd7)) state_nxt = PARITY;
            PARITY:  if (tick) state_nxt = STOP;
`else
            DATA:    if (tick && (bit_cnt == 3'd7)) state_nxt = STOP;
`endif
            STOP:    if (tick) state_nxt = fifo_empty ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: read strobe gated by empty, line level for the next cycle
    always_comb begin
        fifo_rd_en = (state == FETCH) && !fifo_empty;
        busy       = (state != IDLE);
        serial_d   = IDLE_LEVEL;
        case (state)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    // Byte shift register (and parity) loaded in LOAD, shifted on each data tick
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift_q <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= ^fifo_dout;
`endif
        end else if ((state == DATA) && tick) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Data-bit index, counts 0..7 across the DATA state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
        end else if ((state == IDLE) || (state == LOAD)) begin
            bit_cnt <= 3'd0;
        end else if ((state == DATA) && tick) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Registered line driver; reset forces it high immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_out <= IDLE_LEVEL;
        end else begin
            serial_out <= serial_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at 10 clocks per bit, with a FIFO model
// whose read data appears one cycle after rd_en.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_CYC = 110;
    localparam logic [31:0] A5_FRAME = 32'h54A;
    localparam logic [31:0] F07_FRAME = 32'h60E;
`else
    localparam int FRAME_CYC = 100;
    localparam logic [31:0] A5_FRAME = 32'h34A;
    localparam logic [31:0] F07_FRAME = 32'h20E;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       force_empty;
    logic [7:0] force_dout;
    logic [7:0] dout_q = 8'h00;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       serial_out;
    logic       busy;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int uf_cnt = 0;
    int busy_cnt = 0;
    int low_cnt = 0;
    int tests = 0;
    int fails = 0;

    assign fifo_empty = force_empty | (wr_ptr == rd_ptr);
    assign fifo_dout  = force_empty ? force_dout : dout_q;

    fifo_uart_tx #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .serial_out (serial_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // FIFO model with registered read plus activity counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) uf_cnt <= uf_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (!serial_out) low_cnt <= low_cnt + 1;
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            dout_q <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_low(input string tag);
        int n = 0;
        while ((serial_out !== 1'b0) && (n < 400)) begin
            step(1);
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0) && (n < 400)) begin
            step(1);
            n++;
        end
        check({tag, "_idle_seen"}, 32'(n < 400), 32'd1);
    endtask

    // Sample one frame at bit centres, returning the bits (bit 0 = start bit)
    task automatic rx_frame(input string tag, output logic [10:0] bits, output int t0);
        bits = '0;
        wait_low(tag);
        t0 = cyc;
        step(5);
        for (int i = 0; i < FRAME_BITS; i++) begin
            bits[i] = serial_out;
            if (i < FRAME_BITS - 1) step(10);
        end
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  exp_b [0:7];
        int t0, tprev, t_rd, rd0, b0, l0;

        rst = 1'b1;
        force_empty = 1'b0;
        force_dout = 8'h00;

        // Reset and idle with an empty FIFO
        step(3);
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        step(50);
        check("idle_serial", 32'(serial_out), 32'd1);
        check("idle_rd_cnt", 32'(rd_cnt), 32'd0);
        check("idle_busy_cnt", 32'(busy_cnt), 32'd0);
        check("idle_low_cnt", 32'(low_cnt), 32'd0);

        // Single byte A5: latency, bit pattern, busy span
        rd0 = rd_cnt;
        b0 = busy_cnt;
        push(8'hA5);
        step(1);
        check("a5_rd_pulse", 32'(fifo_rd_en), 32'd1);
        t_rd = cyc;
        rx_frame("a5", bits, t0);
        check("a5_latency", 32'(t0 - t_rd), 32'd3);
        check("a5_frame_bits", 32'(bits), A5_FRAME);
        wait_idle("a5");
        check("a5_rd_count", 32'(rd_cnt - rd0), 32'd1);
        check("a5_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME_CYC + 2));
        check("a5_line_idle", 32'(serial_out), 32'd1);

        // Eight preloaded random bytes sent back-to-back
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_b[i] = 8'($urandom);
            push(exp_b[i]);
        end
        tprev = 0;
        for (int i = 0; i < 8; i++) begin
            rx_frame($sformatf("burst%0d", i), bits, t0);
            check($sformatf("burst%0d_data", i), 32'(bits[8:1]), 32'(exp_b[i]));
            check($sformatf("burst%0d_start", i), 32'(bits[0]), 32'd0);
            check($sformatf("burst%0d_stop", i), 32'(bits[FRAME_BITS-1]), 32'd1);
            if (i > 0) check($sformatf("burst%0d_spacing", i), 32'(t0 - tprev), 32'(FRAME_CYC + 2));
            tprev = t0;
        end
        wait_idle("burst");
        check("burst_rd_count", 32'(rd_cnt - rd0), 32'd8);
        check("burst_empty", 32'(fifo_empty), 32'd1);
        check("burst_rd_en_low", 32'(fifo_rd_en), 32'd0);

        // Reset at cycle 37 of a 3C frame: dropped, not replayed
        push(8'h3C);
        wait_low("rst37");
        step(37);
        rst = 1'b1;
        #1;
        check("rst37_serial_async", 32'(serial_out), 32'd1);
        check("rst37_busy", 32'(busy), 32'd0);
        step(2);
        rst = 1'b0;
        rd0 = rd_cnt;
        l0 = low_cnt;
        step(100);
        check("rst37_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("rst37_no_low", 32'(low_cnt - l0), 32'd0);
        check("rst37_serial", 32'(serial_out), 32'd1);
        check("rst37_empty", 32'(fifo_empty), 32'd1);

        // Reset while the start bit drives the line low
        push(8'h3C);
        wait_low("rst5");
        step(5);
        check("rst5_line_low", 32'(serial_out), 32'd0);
        rst = 1'b1;
        #1;
        check("rst5_serial_async", 32'(serial_out), 32'd1);
        step(2);
        rst = 1'b0;
        step(2);

        // Underflow: empty held high with data queued and dout toggling
        force_empty = 1'b1;
        push(8'h55);
        rd0 = rd_cnt;
        l0 = low_cnt;
        b0 = busy_cnt;
        for (int i = 0; i < 100; i++) begin
            force_dout = 8'($urandom);
            step(1);
        end
        check("uf_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("uf_no_low", 32'(low_cnt - l0), 32'd0);
        check("uf_no_busy", 32'(busy_cnt - b0), 32'd0);
        force_empty = 1'b0;
        rx_frame("uf_release", bits, t0);
        check("uf_release_data", 32'(bits[8:1]), 32'h55);
        wait_idle("uf_release");

        // Byte 07: parity bit and frame length
        b0 = busy_cnt;
        push(8'h07);
        rx_frame("f07", bits, t0);
        check("f07_frame_bits", 32'(bits), F07_FRAME);
        wait_idle("f07");
        check("f07_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME_CYC + 2));

        check("no_underflow_ever", 32'(uf_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
